coef_loader: RTL

COEF_LOADER -- requirements
Module: coef_loader

---
 rtl/coef_loader_if.sv | 11 +
 rtl/coef_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/coef_loader_if.sv
// Write-word channel into coef_loader: 32-bit header/data words.
// Latency: n/a (wires only).
// Backpressure: a word moves only on a cycle where wr_valid && wr_ready.
interface coef_loader_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/coef_loader.sv
// Coefficient loader: parses header/LO/HI words into a shadow bank, publishes it to the active bank on step.
// Latency: active outputs change 1 cycle after the publishing step edge; commit_done follows in that cycle.
// Backpressure: wr_ready drops for the single write-back cycle after each entry and while rst is high.
module coef_loader #(
  parameter int N_MAX      = 6,
  parameter int DATA_WIDTH = 43
) (
  input  logic                               clk,
  input  logic                               rst,
  coef_loader_if.slave                       wr,
  input  logic                               commit,
  input  logic                               step,
  input  logic                               err_clr,
  output logic [N_MAX*N_MAX*DATA_WIDTH-1:0]  Ah_on,
  output logic [N_MAX*N_MAX*DATA_WIDTH-1:0]  Ah_off,
  output logic [N_MAX*N_MAX*DATA_WIDTH-1:0]  C,
  output logic [N_MAX*DATA_WIDTH-1:0]        Bh_on,
  output logic [N_MAX*DATA_WIDTH-1:0]        Bh_off,
  output logic [7:0]                         size,
  output logic                               params_valid,
  output logic                               commit_pending,
  output logic                               commit_done,
  output logic                               err
);

  localparam int          MW = N_MAX*N_MAX*DATA_WIDTH;
  localparam int          VW = N_MAX*DATA_WIDTH;
  localparam logic [7:0]  N8 = 8'(N_MAX);

  typedef enum logic [1:0] {S_HDR, S_LO, S_HI, S_WR} state_t;

  state_t state, state_nxt;

  logic        accept, hdr_ok, hdr_bad, ent_bad, do_write, publish, legal;
  logic [2:0]  sel_q;
  logic [7:0]  row_q, col_q;
  logic [31:0] lo_q;
  logic [10:0] hi_q;
  int          mat_idx, vec_idx;
  logic [DATA_WIDTH-1:0] entry;

  logic [MW-1:0] sh_ah_on, sh_ah_off, sh_c;
  logic [VW-1:0] sh_bh_on, sh_bh_off;
  logic [7:0]    sh_size;

  assign accept  = wr.wr_valid && wr.wr_ready;
  assign hdr_ok  = (wr.wr_data[31:28] == 4'hA);
  assign entry   = DATA_WIDTH'({hi_q, lo_q});
  assign mat_idx = int'(row_q) * N_MAX + int'(col_q);
  assign vec_idx = int'(row_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_HDR;
    else     state <= state_nxt;
  end

  // Next state: header, low word, high word (skipped for size), one write-back cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR: if (accept && hdr_ok) state_nxt = S_LO;
      S_LO:  if (accept) state_nxt = (sel_q == 3'd5) ? S_WR : S_HI;
      S_HI:  if (accept) state_nxt = S_WR;
      S_WR:  state_nxt = S_HDR;
      default: state_nxt = S_HDR;
    endcase
  end

  // Outputs of the FSM: ready, write/err strobes and the publish decision.
  always_comb begin
    wr.wr_ready = !rst && (state != S_WR);
    hdr_bad     = (state == S_HDR) && accept && !hdr_ok;
    do_write    = (state == S_WR) && legal;
    ent_bad     = (state == S_WR) && !legal;
    publish     = (state == S_HDR) && step && (commit_pending || commit);
  end

  // Entry legality, judged on the captured header and low word.
  always_comb begin
    legal = 1'b1;
    if (sel_q > 3'd5)                                   legal = 1'b0;
    if (row_q >= N8 || col_q >= N8)                     legal = 1'b0;
    if ((sel_q == 3'd1 || sel_q == 3'd3) && col_q != 8'd0) legal = 1'b0;
    if (sel_q == 3'd5 && (row_q != 8'd0 || col_q != 8'd0 ||
                          lo_q[7:0] == 8'd0 || lo_q[7:0] > N8))
      legal = 1'b0;
  end

  // Capture header fields and data words as they are accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0; row_q <= '0; col_q <= '0; lo_q <= '0; hi_q <= '0;
    end else if (accept) begin
      case (state)
        S_HDR: if (hdr_ok) begin
          sel_q <= wr.wr_data[26:24];
          row_q <= wr.wr_data[15:8];
          col_q <= wr.wr_data[7:0];
        end
        S_LO:    lo_q <= wr.wr_data;
        S_HI:    hi_q <= wr.wr_data[10:0];
        default: ;
      endcase
    end
  end

  // Shadow bank: a legal entry lands here only, never directly on the active outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_ah_on <= '0; sh_ah_off <= '0; sh_c <= '0;
      sh_bh_on <= '0; sh_bh_off <= '0; sh_size <= '0;
    end else if (do_write) begin
      for (int i = 0; i < N_MAX*N_MAX; i++) begin
        if (i == mat_idx) begin
          if (sel_q == 3'd0) sh_ah_on[i*DATA_WIDTH +: DATA_WIDTH]  <= entry;
          if (sel_q == 3'd2) sh_ah_off[i*DATA_WIDTH +: DATA_WIDTH] <= entry;
          if (sel_q == 3'd4) sh_c[i*DATA_WIDTH +: DATA_WIDTH]      <= entry;
        end
      end
      for (int i = 0; i < N_MAX; i++) begin
        if (i == vec_idx) begin
          if (sel_q == 3'd1) sh_bh_on[i*DATA_WIDTH +: DATA_WIDTH]  <= entry;
          if (sel_q == 3'd3) sh_bh_off[i*DATA_WIDTH +: DATA_WIDTH] <= entry;
        end
      end
      if (sel_q == 3'd5) sh_size <= lo_q[7:0];
    end
  end

  // Active bank: whole shadow copied in one cycle at publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      Ah_on <= '0; Ah_off <= '0; C <= '0;
      Bh_on <= '0; Bh_off <= '0; size <= '0;
    end else if (publish) begin
      Ah_on <= sh_ah_on; Ah_off <= sh_ah_off; C <= sh_c;
      Bh_on <= sh_bh_on; Bh_off <= sh_bh_off; size <= sh_size;
    end
  end

  // Commit bookkeeping and sticky error; a new error wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pending <= 1'b0;
      params_valid   <= 1'b0;
      commit_done    <= 1'b0;
      err            <= 1'b0;
    end else begin
      if (publish)     commit_pending <= 1'b0;
      else if (commit) commit_pending <= 1'b1;
      if (publish)     params_valid   <= 1'b1;
      commit_done <= publish;
      err         <= (err && !err_clr) || hdr_bad || ent_bad;
    end
  end

endmodule
